// File: rtl/endec_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : endec_scheduler_pkg
// Brief    : Shared types and constants for the encoder/decoder job scheduler:
//            FSM state enum, core mode encoding, configuration widths and
//            default parameter values.
// Revision : 1.0 - initial release
// ============================================================================
package endec_scheduler_pkg;

  // Core configuration geometry; port widths are derived from these.
  localparam int MAX_CODE_RATE         = 2;
  localparam int MAX_CONSTRAINT_LENGTH = 4;
  localparam int CODE_RATE_W           = $clog2(MAX_CODE_RATE);
  localparam int CONSTR_LEN_W          = $clog2(MAX_CONSTRAINT_LENGTH);
  localparam int GEN_POLY_W            = MAX_CODE_RATE * MAX_CONSTRAINT_LENGTH;

  // Default parameter values for the scheduler top.
  localparam int TIMEOUT_CYC_DEF = 1023;
  localparam int LEN_W_DEF       = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_ACK   = 3'd4
  } sched_state_e;

  // Value driven on the core's mode select.
  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  // Bits needed to hold a counter that may reach max_val.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/endec_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : endec_scheduler_if
// Brief    : Job request, configuration and core-control bundle between the
//            requesters/core (master) and the scheduler (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface endec_scheduler_if
  import endec_scheduler_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) ();

  // Requests and job configuration
  logic                    i_enc_req;
  logic [LEN_W-1:0]        i_enc_len;
  logic                    i_dec_req;
  logic [CODE_RATE_W-1:0]  i_code_rate;
  logic [CONSTR_LEN_W-1:0] i_constr_len;
  logic [GEN_POLY_W-1:0]   i_gen_poly;

  // Completion pulses from the core
  logic                    i_encoder_done;
  logic                    i_decoder_done;

  // Core control and latched configuration
  logic                    o_en;
  logic                    o_mode_sel;
  logic [CODE_RATE_W-1:0]  o_code_rate;
  logic [CONSTR_LEN_W-1:0] o_constr_len;
  logic [GEN_POLY_W-1:0]   o_gen_poly;

  // Job status
  logic                    o_enc_ack;
  logic                    o_dec_ack;
  logic                    o_busy;
  logic                    o_err_timeout;

  modport slave (
    input  i_enc_req, i_enc_len, i_dec_req, i_code_rate, i_constr_len,
           i_gen_poly, i_encoder_done, i_decoder_done,
    output o_en, o_mode_sel, o_code_rate, o_constr_len, o_gen_poly,
           o_enc_ack, o_dec_ack, o_busy, o_err_timeout
  );

  modport master (
    output i_enc_req, i_enc_len, i_dec_req, i_code_rate, i_constr_len,
           i_gen_poly, i_encoder_done, i_decoder_done,
    input  o_en, o_mode_sel, o_code_rate, o_constr_len, o_gen_poly,
           o_enc_ack, o_dec_ack, o_busy, o_err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/endec_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : endec_rr_arbiter
// Brief    : Two-way round-robin arbiter between encode and decode requests.
//            A lone request always wins; with both pending the side not
//            granted last time wins. Encoder has priority out of reset.
// Revision : 1.0 - initial release
// ============================================================================
module endec_rr_arbiter (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_req_enc,
  input  wire logic i_req_dec,
  input  wire logic i_grant_en,
  output logic      o_gnt_enc,
  output logic      o_gnt_dec
);

  // Set when the decoder should win the next tie.
  logic r_prio_dec;

  // Combinational winner selection from the current requests and pointer.
  always_comb begin
    o_gnt_dec = i_req_dec & (~i_req_enc | r_prio_dec);
    o_gnt_enc = i_req_enc & ~o_gnt_dec;
  end

  // Pointer moves to the side that did not just win, only when a grant is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio_dec <= 1'b0;
    end else if (i_grant_en) begin
      r_prio_dec <= o_gnt_enc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/endec_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : endec_scheduler
// Brief    : Arbitrates encode/decode jobs onto a shared convolutional
//            encoder/decoder core: latches job configuration, enables the
//            core, tracks completion or timeout and pulses the job ack.
// Revision : 1.0 - initial release
// ============================================================================
module endec_scheduler
  import endec_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int LEN_W       = LEN_W_DEF
) (
  input wire logic         sys_clk,
  input wire logic         rst,
  endec_scheduler_if.slave bus
);

  localparam int                   RUN_CNT_W  = cnt_width(TIMEOUT_CYC);
  localparam logic [RUN_CNT_W-1:0] C_RUN_LAST = RUN_CNT_W'(TIMEOUT_CYC - 1);

  sched_state_e            r_state;
  sched_state_e            w_next_state;

  logic                    r_win_dec;
  mode_e                   r_mode;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_enc_cnt;
  logic [RUN_CNT_W-1:0]    r_run_cnt;
  logic                    r_err_timeout;
  logic [CODE_RATE_W-1:0]  r_code_rate;
  logic [CONSTR_LEN_W-1:0] r_constr_len;
  logic [GEN_POLY_W-1:0]   r_gen_poly;

  logic                    w_gnt_enc;
  logic                    w_gnt_dec;
  logic                    w_grant;
  logic                    w_enc_exit;
  logic                    w_dec_exit;
  logic                    w_job_exit;
  logic                    w_timeout;

  endec_rr_arbiter u_arb (
    .clk        (sys_clk),
    .rst        (rst),
    .i_req_enc  (bus.i_enc_req),
    .i_req_dec  (bus.i_dec_req),
    .i_grant_en (w_grant),
    .o_gnt_enc  (w_gnt_enc),
    .o_gnt_dec  (w_gnt_dec)
  );

  // Job exit and timeout detection; done pulses only matter while running.
  always_comb begin
    w_grant    = (r_state == ST_IDLE) && (w_gnt_enc || w_gnt_dec);
    w_enc_exit = (r_state == ST_RUN) && (r_mode == MODE_ENC) && bus.i_encoder_done
                 && ((r_enc_cnt + LEN_W'(1)) == r_len);
    w_dec_exit = (r_state == ST_RUN) && (r_mode == MODE_DEC) && bus.i_decoder_done;
    w_job_exit = w_enc_exit || w_dec_exit;
    w_timeout  = (r_state == ST_RUN) && !w_job_exit && (r_run_cnt == C_RUN_LAST);
  end

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and state-decoded core/status outputs.
  always_comb begin
    w_next_state  = r_state;
    bus.o_en      = 1'b0;
    bus.o_busy    = 1'b1;
    bus.o_enc_ack = 1'b0;
    bus.o_dec_ack = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        bus.o_busy = 1'b0;
        if (w_grant) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_next_state = ST_RUN;
      end
      ST_RUN: begin
        bus.o_en = 1'b1;
        if (w_job_exit || w_timeout) w_next_state = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_next_state = ST_ACK;
      end
      ST_ACK: begin
        bus.o_enc_ack = (r_mode == MODE_ENC);
        bus.o_dec_ack = (r_mode == MODE_DEC);
        w_next_state  = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Job datapath: winner capture, configuration latch, job counters, error flag.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_win_dec     <= 1'b0;
      r_mode        <= MODE_ENC;
      r_len         <= '0;
      r_enc_cnt     <= '0;
      r_run_cnt     <= '0;
      r_err_timeout <= 1'b0;
      r_code_rate   <= '0;
      r_constr_len  <= '0;
      r_gen_poly    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant) r_win_dec <= w_gnt_dec;
        end
        ST_LOAD: begin
          r_mode        <= r_win_dec ? MODE_DEC : MODE_ENC;
          r_len         <= bus.i_enc_len;
          r_code_rate   <= bus.i_code_rate;
          r_constr_len  <= bus.i_constr_len;
          r_gen_poly    <= bus.i_gen_poly;
          r_enc_cnt     <= '0;
          r_run_cnt     <= '0;
          r_err_timeout <= 1'b0;
        end
        ST_RUN: begin
          r_run_cnt <= r_run_cnt + RUN_CNT_W'(1);
          if ((r_mode == MODE_ENC) && bus.i_encoder_done) begin
            r_enc_cnt <= r_enc_cnt + LEN_W'(1);
          end
          if (w_timeout) r_err_timeout <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_mode_sel    = r_mode;
  assign bus.o_code_rate   = r_code_rate;
  assign bus.o_constr_len  = r_constr_len;
  assign bus.o_gen_poly    = r_gen_poly;
  assign bus.o_err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_endec_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_endec_scheduler
// Brief    : Directed self-checking bench for endec_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_endec_scheduler;
  import endec_scheduler_pkg::*;

  localparam int C_TIMEOUT = 16;
  localparam int C_LEN_W   = 8;

  logic sys_clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  endec_scheduler_if #(.LEN_W(C_LEN_W)) bus ();

  endec_scheduler #(
    .TIMEOUT_CYC (C_TIMEOUT),
    .LEN_W       (C_LEN_W)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Runs one job starting from an IDLE cycle where the winning request is
  // already asserted; run_len is the RUN cycle carrying the exit pulse.
  task automatic serve(input logic exp_dec, input int run_len);
    tick();
    check("load_busy", bus.o_busy, 1);
    check("load_en", bus.o_en, 0);
    tick();
    check("run_mode", bus.o_mode_sel, exp_dec);
    for (int k = 1; k <= run_len; k++) begin
      check("run_en", bus.o_en, 1);
      if (exp_dec) bus.i_decoder_done = (k == run_len);
      else         bus.i_encoder_done = 1'b1;
      tick();
    end
    bus.i_encoder_done = 1'b0;
    bus.i_decoder_done = 1'b0;
    check("flush_en", bus.o_en, 0);
    check("flush_acks", {bus.o_enc_ack, bus.o_dec_ack}, 2'b00);
    tick();
    check("ack", {bus.o_enc_ack, bus.o_dec_ack}, exp_dec ? 2'b01 : 2'b10);
    check("ack_err", bus.o_err_timeout, 0);
    tick();
    check("idle_busy", bus.o_busy, 0);
    check("idle_acks", {bus.o_enc_ack, bus.o_dec_ack}, 2'b00);
    if (exp_dec) bus.i_dec_req = 1'b0;
    else         bus.i_enc_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {bus.o_en, bus.o_mode_sel, bus.o_enc_ack, bus.o_dec_ack,
                bus.o_busy, bus.o_err_timeout, bus.o_code_rate,
                bus.o_constr_len, bus.o_gen_poly}, 32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.i_enc_req      = 1'b0;
    bus.i_enc_len      = '0;
    bus.i_dec_req      = 1'b0;
    bus.i_code_rate    = '0;
    bus.i_constr_len   = '0;
    bus.i_gen_poly     = '0;
    bus.i_encoder_done = 1'b0;
    bus.i_decoder_done = 1'b0;

    // Reset state
    tick();
    tick();
    check_all_zero("reset_outputs");
    rst = 1'b0;

    // Encode len=4, done every cycle; config changes during RUN are ignored
    bus.i_enc_req    = 1'b1;
    bus.i_enc_len    = 8'd4;
    bus.i_code_rate  = 1'b1;
    bus.i_constr_len = 2'd2;
    bus.i_gen_poly   = 8'hA5;
    tick();
    check("encA_load_busy", bus.o_busy, 1);
    check("encA_load_en", bus.o_en, 0);
    tick();
    check("encA_mode", bus.o_mode_sel, 0);
    check("encA_cfg", {bus.o_code_rate, bus.o_constr_len, bus.o_gen_poly}, {1'b1, 2'd2, 8'hA5});
    bus.i_code_rate  = 1'b0;
    bus.i_constr_len = 2'd1;
    bus.i_gen_poly   = 8'h5A;
    bus.i_enc_len    = 8'd9;
    bus.i_encoder_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("encA_run_en", bus.o_en, 1);
      check("encA_run_cfg", {bus.o_code_rate, bus.o_constr_len, bus.o_gen_poly}, {1'b1, 2'd2, 8'hA5});
      tick();
    end
    check("encA_flush_en", bus.o_en, 0);
    check("encA_flush_ack", bus.o_enc_ack, 0);
    tick();
    check("encA_ack", {bus.o_enc_ack, bus.o_dec_ack}, 2'b10);
    bus.i_encoder_done = 1'b0;
    tick();
    bus.i_enc_req = 1'b0;
    check("encA_idle_busy", bus.o_busy, 0);
    check("encA_cfg_held", {bus.o_code_rate, bus.o_gen_poly}, {1'b1, 8'hA5});

    // Done pulses while idle are ignored
    bus.i_encoder_done = 1'b1;
    bus.i_decoder_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_done_ignored", {bus.o_busy, bus.o_en, bus.o_enc_ack, bus.o_dec_ack}, 4'b0000);
    end
    bus.i_encoder_done = 1'b0;
    bus.i_decoder_done = 1'b0;

    // Shortest legal encode job, len=1
    bus.i_enc_req = 1'b1;
    bus.i_enc_len = 8'd1;
    serve(1'b0, 1);

    // Asynchronous reset pulse restores encoder-first priority
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset_idle");
    tick();
    rst = 1'b0;

    // Two back-to-back simultaneous pairs: enc, dec, enc, dec
    bus.i_enc_len = 8'd2;
    for (int p = 0; p < 2; p++) begin
      bus.i_enc_req = 1'b1;
      bus.i_dec_req = 1'b1;
      serve(1'b0, 2);
      serve(1'b1, 3);
    end

    // Decode timeout: no decoder_done, abort after C_TIMEOUT RUN cycles
    bus.i_dec_req = 1'b1;
    tick();
    tick();
    for (int k = 0; k < C_TIMEOUT; k++) begin
      check("to_run_en", bus.o_en, 1);
      tick();
    end
    check("to_flush", {bus.o_en, bus.o_err_timeout}, 2'b01);
    tick();
    check("to_ack", {bus.o_enc_ack, bus.o_dec_ack, bus.o_err_timeout}, 3'b011);
    tick();
    bus.i_dec_req = 1'b0;
    check("to_err_held", {bus.o_busy, bus.o_err_timeout}, 2'b01);

    // Reset in RUN of a decode job: immediate abort, no ack, then re-grant
    bus.i_dec_req = 1'b1;
    bus.i_code_rate = 1'b1;
    bus.i_gen_poly  = 8'h3C;
    tick();
    tick();
    tick();
    check("rr_pre_run", {bus.o_en, bus.o_mode_sel}, 2'b11);
    rst = 1'b1;
    #1;
    check_all_zero("run_reset_outputs");
    tick();
    check("run_reset_no_ack", {bus.o_enc_ack, bus.o_dec_ack, bus.o_busy}, 3'b000);
    rst = 1'b0;
    serve(1'b1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/endec_scheduler.md
ENDEC_SCHEDULER -- requirements
Module: endec_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1023, meaning: max RUN cycles per job before abort.
REQ-002 Parameter LEN_W, default 8, meaning: width of encode-job bit count.
REQ-003 sys_clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 i_enc_req  in  1  encode-job request, held until ack.
REQ-006 i_enc_len  in  LEN_W  encode-job bit count, sampled at grant; 0 is illegal.
REQ-007 i_dec_req  in  1  decode-job request (one frame), held until ack.
REQ-008 i_code_rate  in  1 ; i_constr_len  in  2 ; i_gen_poly  in  MAX_CODE_RATE x MAX_CONSTRAINT_LENGTH: job configuration, sampled at grant.
REQ-009 i_encoder_done  in  1  per-bit done pulse from core; i_decoder_done  in  1  frame done pulse from core.
REQ-010 o_en  out  1  core enable; o_mode_sel  out  1  (0 encode, 1 decode).
REQ-011 o_code_rate, o_constr_len, o_gen_poly  out  widths as REQ-008  latched configuration to core.
REQ-012 o_enc_ack, o_dec_ack  out  1  one-cycle job-complete pulses.
REQ-013 o_busy  out  1 ; o_err_timeout  out  1  status of last job.

Function
REQ-014 FSM states: IDLE, LOAD, RUN, FLUSH, ACK.
REQ-015 IDLE: no request -> stay; any request -> LOAD next cycle with winner recorded.
REQ-016 Arbitration: single request wins; both pending -> round-robin, winner is opposite of last granted; after reset encoder has priority.
REQ-017 LOAD (1 cycle): latch configuration, i_enc_len, mode; clear job counters and o_err_timeout; o_en=0.
REQ-018 RUN: o_en=1; encode counts i_encoder_done pulses, exits when count==latched len; decode exits on first i_decoder_done.
REQ-019 Exit condition seen in cycle N -> o_en=0 from cycle N+1 (FLUSH).
REQ-020 FLUSH (1 cycle, o_en=0) -> ACK; ACK (1 cycle) pulses winner's ack -> IDLE.
REQ-021 Ack latency: decode = done cycle + 2; min job turnaround from grant = 4 cycles plus RUN length.
REQ-022 Timeout: RUN cycle counter reaches TIMEOUT_CYC without exit -> o_err_timeout=1, FLUSH, ACK; flag held until next LOAD.
REQ-023 Done pulses outside RUN are ignored.
REQ-024 Request/config changes after LOAD do not affect the running job.
REQ-025 Requester deasserts req the cycle after ack; req still high in IDLE after ack = new job.
REQ-026 Encode count counter width LEN_W; no wrap possible since exit at equality.
REQ-027 o_busy=1 in every state except IDLE.
REQ-028 Both ack outputs never high in the same cycle.

Reset
REQ-029 rst asserted: state IDLE, o_en=0, o_mode_sel=0, config outputs 0, acks 0, o_busy=0, o_err_timeout=0, round-robin pointer = encoder-first, counters 0.
REQ-030 rst mid-job aborts immediately with no ack; pending requests re-arbitrated after release.

Structure
REQ-031 FSM state enum, mode encoding, and TIMEOUT default in shared package; widths from MAX_CODE_RATE, MAX_CONSTRAINT_LENGTH.
REQ-032 One sub-module natural: endec_rr_arbiter (2-way round-robin, pointer update on grant).
REQ-033 endec_scheduler drives the core's en, i_mode_sel and configuration inputs; core's own internal sequencer is unchanged.

Verification
REQ-034 enc_req, len=4, done pulses every cycle -> o_en high 4 cycles, o_enc_ack 2 cycles after 4th pulse, o_mode_sel=0.
REQ-035 enc_req and dec_req same cycle from reset -> encoder served first, then decoder (o_mode_sel=1), acks in that order.
REQ-036 Two back-to-back simultaneous request pairs -> grant sequence enc, dec, enc, dec.
REQ-037 dec_req, no decoder_done, TIMEOUT_CYC=16 -> o_en drops after 16 RUN cycles, o_dec_ack with o_err_timeout=1.
REQ-038 rst pulse in RUN of decode -> all outputs zero next edge, no ack; pending req re-granted after release.
REQ-039 Change i_code_rate/i_gen_poly during RUN -> outputs keep values latched at LOAD.
